// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/replication and alignment check on the issue side,
// lane selection and sign/zero extension on the load side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_data_out,
    output logic [3:0]  mask,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Issue side: size is funct3[1:0]; the unsigned bit does not affect lanes.
    always_comb begin
        mask       = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd0: begin
                mask  = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                mask       = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            2'd2: begin
                mask       = 4'b1111;
                misaligned = |offset;
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = mem_data_out >> {offset, 3'b000};
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one command at a time through IDLE -> ISSUE -> (WAIT) -> DONE.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_mask,
    input  logic        mem_valid,
    input  logic [31:0] mem_data_out
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  maddr_q, maddr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] load_q, load_d;

    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic        al_misaligned;
    logic [31:0] al_rdata;
    logic        illegal;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:10];

    // One aligner serves both sides: live inputs while idle, latched command afterwards.
    assign al_f3  = (state_q == StIdle) ? funct3    : f3_q;
    assign al_off = (state_q == StIdle) ? addr[1:0] : off_q;

    lsu_align u_align (
        .funct3       (al_f3),
        .offset       (al_off),
        .store_data   (store_data),
        .mem_data_out (mem_data_out),
        .mask         (al_mask),
        .wdata        (al_wdata),
        .misaligned   (al_misaligned),
        .rdata_ext    (al_rdata)
    );

    assign illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
                     (is_store && funct3[2]) || al_misaligned;

    // Next-state and command latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        maddr_d = maddr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_d   = err_q;
        load_d  = load_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        maddr_d = addr[9:2];
                        mask_d  = al_mask;
                        wdata_d = al_wdata;
                        we_d    = is_store;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = 8'd0;
                state_d = we_q ? StDone : StWait;
            end
            StWait: begin
                if (mem_valid) begin
                    load_d  = al_rdata;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutCnt) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            maddr_q <= 8'd0;
            mask_q  <= 4'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            err_q   <= 1'b0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            maddr_q <= maddr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err         = done && err_q;
    assign mem_request = (state_q == StIssue);
    assign mem_we_re   = mem_request && we_q;
    assign mem_address = maddr_q;
    assign mem_mask    = mask_q;
    assign mem_data_in = wdata_q;
    assign load_data   = load_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the RV32I core's execute stage and the word-addressed `memory` block. It accepts one load or store command and converts the byte address and `funct3` into a word address, byte mask and lane-replicated store data. It runs the `request`/`we_re`/`valid` exchange with memory, then sign- or zero-extends the returned load data. It also detects misaligned and unsupported accesses without touching memory.

## Interface
- `TIMEOUT`, 15: maximum cycles spent in WAIT for `mem_valid` before an access aborts with an error; legal range 1–255.
- `clk` in 1: clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: access size and sign; loads LB=0, LH=1, LW=2, LBU=4, LHU=5; stores SB=0, SH=1, SW=2.
- `addr` in 32: byte address.
- `store_data` in 32: store source, with the byte or half in the low bits.
- `busy` out 1: a command is in flight.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; the access was misaligned, had an illegal `funct3`, or timed out.
- `load_data` out 32: extended load result; held until the next `done`.
- `mem_request` out 1: memory request.
- `mem_we_re` out 1: 1 = write, 0 = read.
- `mem_address` out 8: word address, equal to `addr[9:2]`.
- `mem_data_in` out 32: lane-replicated write data.
- `mem_mask` out 4: byte-lane enables.
- `mem_valid` in 1: memory read-data valid. It is sticky: it rises on a read and clears only on a later write.
- `mem_data_out` in 32: memory read word.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, `start` high, legal access: register `mem_address`, `mem_mask`, `mem_data_in`, `mem_we_re`, `funct3` and `addr[1:0]`, then go to ISSUE.
- IDLE, `start` high, illegal access: go to DONE with `err` set; no memory request is made.
- An access is illegal if any of these hold:
  - halfword access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - `funct3` of 3, 6 or 7;
  - store with `funct3` ≥ 3.
- ISSUE: `mem_request` = 1 for exactly this one cycle.
  - Store: go to DONE.
  - Load: go to WAIT with the timeout counter cleared.
- WAIT:
  - `mem_valid` = 1: latch the extended `mem_data_out` into `load_data` and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `err` and go to DONE; `load_data` is left unchanged.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Mask for byte lane b = `addr[1:0]`:
  - byte access: `4'b0001 << b`;
  - halfword access: `4'b0011 << b`;
  - word access: `4'b1111`.
- Store data replication:
  - SB: the byte copied into all 4 lanes;
  - SH: the halfword copied into both halves;
  - SW: passed through unchanged.
- Load extraction:
  - select byte `mem_data_out[8b+7:8b]`, or halfword `mem_data_out[8b+15:8b]`;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- `start` is ignored whenever the FSM is not in IDLE; there is no queueing.
- `store_data`, `addr`, `funct3` and `is_store` only need to be stable in the `start` cycle.
- `mem_address`, `mem_mask` and `mem_data_in` are registered outputs and stay constant from ISSUE through DONE.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `err`, `mem_request` and `mem_we_re` all 0;
  - `mem_mask` = 0, `mem_address` = 0, `mem_data_in` = 0, `load_data` = 0;
  - timeout counter 0.
- Legal store, `start` sampled at edge 0:
  - cycle 1: ISSUE, `mem_request` = 1, `mem_we_re` = 1;
  - memory writes at edge 2;
  - cycle 2: `done` = 1.
- Legal load, `start` sampled at edge 0:
  - cycle 1: ISSUE;
  - cycle 2: WAIT sees `mem_valid` = 1;
  - cycle 3: `done` = 1 with `load_data` valid.
- Illegal access: `done` and `err` both high in cycle 1.
- `busy` is high in every non-IDLE state, including DONE.
- A new `start` is accepted in the first IDLE cycle after DONE, so command-to-command spacing is 3 cycles for a store and 4 for a load.
- `mem_request` and `mem_we_re` are 0 outside ISSUE.
- `rst` mid-operation: IDLE on the next edge, no `done` pulse, `mem_request` dropped.
  - A write already committed at an earlier edge stays committed.
- `err` is meaningful only while `done` = 1; it is 0 otherwise.

## Structure
- Package `lsu_pkg` holds:
  - the `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum typedef `lsu_state_t`.
- Sub-module `lsu_align`, purely combinational, computes from `funct3`, `addr[1:0]`, `store_data` and `mem_data_out`:
  - `mask`, `wdata` and `misaligned` for the issue side;
  - `rdata_ext` for the load side.
- `lsu` holds the FSM, the timeout counter and the output registers.

## Test plan
- SB `addr` = 0x0000_0106, `store_data` = 0x0000_00A5 → ISSUE cycle shows `mem_address` = 0x41, `mem_mask` = 4'b0100, `mem_data_in` = 0xA5A5_A5A5; `done` in cycle 2, `err` = 0.
- Memory word 0x41 = 0x80FF_7F01: LB at 0x107 → 0xFFFF_FF80; LBU at 0x107 → 0x0000_0080; LH at 0x104 → 0x0000_7F01; LHU at 0x106 → 0x0000_80FF.
- SW 0xDEAD_BEEF to 0x10, then LW from 0x10 → `load_data` = 0xDEAD_BEEF, `done` in cycle 3 after the load `start`.
- LW at 0x102, SH at 0x101 and `funct3` = 3 → each gives `done` = `err` = 1 in cycle 1 with `mem_request` never asserted.
- `start` held high across a whole load, then `rst` pulsed during WAIT → only one command executes; after reset all outputs are 0 and no `done` pulse appears.
- Memory model holding `mem_valid` = 0 (after a write), load issued with `TIMEOUT` = 4 → `done` = `err` = 1 after 4 WAIT cycles, and `load_data` keeps its prior value.
